// File: rtl/tff.sv
// tff: parameterised bank of synchronous toggle flip-flops.
// Each bit of q inverts on a rising clk edge when its d bit is high.
// An active-low synchronous reset loads RESET_VALUE and overrides any toggle.
// q comes straight from flops, so there is no combinational path from d or reset to q.
module tff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Toggle value: every bit is independent, so the next state is a per-bit XOR.
  // X on a d bit propagates only into that bit.
  assign q_next = q_reg ^ d;

  // State register: reset wins over toggle, otherwise take the toggled value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: tb/tb_tff.sv
// tb_tff: table-driven directed checks of the tff toggle register.
// A 1-bit instance covers reset, hold, toggle, reset priority and glitch cases.
// A 4-bit instance with a non-zero reset value covers per-bit independence.
module tb_tff;

  logic       clk;
  logic       reset1;
  logic       d1;
  logic       q1;
  logic       reset4;
  logic [3:0] d4;
  logic [3:0] q4;

  int errors = 0;
  int checks = 0;

  // Clock with a 100 ns period; the first rising edge is at 50 ns.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  tff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .d(d1), .clk(clk), .reset(reset1), .q(q1)
  );

  tff #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .d(d4), .clk(clk), .reset(reset4), .q(q4)
  );

  typedef struct {
    logic  rst;
    logic  d;
    logic  q;
    string name;
  } vec_t;

  vec_t vecs[10];

  // Compare one value and print one line per transaction.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: q=%b at %0t", name, act, $time);
    end
  endtask

  // Wait for the next rising edge, then sample just after it.
  task automatic edge_and_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table: inputs applied before an edge, q expected just after it.
    vecs[0] = '{1'b0, 1'b0, 1'b0, "reset d=0"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, "reset d=0 again"};
    vecs[2] = '{1'b0, 1'b1, 1'b0, "reset overrides toggle"};
    vecs[3] = '{1'b1, 1'b0, 1'b0, "hold 1"};
    vecs[4] = '{1'b1, 1'b0, 1'b0, "hold 2"};
    vecs[5] = '{1'b1, 1'b1, 1'b1, "toggle 1"};
    vecs[6] = '{1'b1, 1'b1, 1'b0, "toggle 2"};
    vecs[7] = '{1'b1, 1'b1, 1'b1, "toggle 3"};
    vecs[8] = '{1'b1, 1'b1, 1'b0, "toggle 4"};
    vecs[9] = '{1'b1, 1'b1, 1'b1, "toggle 5"};

    reset4 = 1'b0;
    d4     = 4'b0000;

    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      reset1 = vecs[i].rst;
      d1     = vecs[i].d;
      edge_and_settle();
      check(vecs[i].name, {3'b000, q1}, {3'b000, vecs[i].q});
    end

    // Reset mid-toggle: q is 1 here; dropping reset between edges must not change q yet.
    #20;
    reset1 = 1'b0;
    d1     = 1'b1;
    #10;
    check("reset dropped between edges", {3'b000, q1}, 4'b0001);
    edge_and_settle();
    check("reset takes effect at edge", {3'b000, q1}, 4'b0000);
    edge_and_settle();
    check("reset held with d=1", {3'b000, q1}, 4'b0000);

    // Reset release with d high toggles on the first edge reset is seen high.
    @(negedge clk);
    reset1 = 1'b1;
    d1     = 1'b1;
    edge_and_settle();
    check("toggle on release edge", {3'b000, q1}, 4'b0001);

    // Inter-edge glitch on d must not alter q.
    @(negedge clk);
    d1 = 1'b0;
    edge_and_settle();
    check("hold before glitch", {3'b000, q1}, 4'b0001);
    #30;
    d1 = 1'b1;
    #20;
    d1 = 1'b0;
    #10;
    check("glitch between edges", {3'b000, q1}, 4'b0001);
    edge_and_settle();
    check("glitch ignored at edge", {3'b000, q1}, 4'b0001);

    // Multi-bit instance: reset value, per-bit toggles and hold.
    @(negedge clk);
    reset4 = 1'b0;
    d4     = 4'b1111;
    edge_and_settle();
    check("w4 reset value", q4, 4'b1010);
    @(negedge clk);
    reset4 = 1'b1;
    d4     = 4'b0110;
    edge_and_settle();
    check("w4 toggle 0110", q4, 4'b1100);
    @(negedge clk);
    d4 = 4'b0000;
    edge_and_settle();
    check("w4 hold", q4, 4'b1100);
    edge_and_settle();
    check("w4 hold again", q4, 4'b1100);
    @(negedge clk);
    d4 = 4'b1001;
    edge_and_settle();
    check("w4 toggle 1001", q4, 4'b0101);
    @(negedge clk);
    d4 = 4'b0001;
    edge_and_settle();
    check("w4 single bit", q4, 4'b0100);
    @(negedge clk);
    reset4 = 1'b0;
    d4     = 4'b1111;
    edge_and_settle();
    check("w4 reset priority", q4, 4'b1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
